// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage handshake with the multi-cycle divider
interface div_seq_if #(parameter int WIDTH = 32);
    logic start, signed_div, annul, ready, stall;
    logic [WIDTH-1:0] opdata1, opdata2;
    logic [2*WIDTH-1:0] result;
    modport master(output start, signed_div, opdata1, opdata2, annul, input result, ready, stall);
    modport slave(input start, signed_div, opdata1, opdata2, annul, output result, ready, stall);
endinterface

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring DIV/DIVU sequencer returning {hi=remainder, lo=quotient}
// DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes one cycle after accept
module div_seq #(parameter int WIDTH = 32) (
    input logic clk,
    input logic resetn,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] rem, dvd, dsr, raw1, nrem, ndvd, abs1, abs2, q, r;
    logic [WIDTH:0] shr, diff;
    logic [CW-1:0] cnt;
    logic qsign, rsign, zero, accept;
    always_comb begin
        accept = state == IDLE && bus.start && !bus.annul;
        abs1 = bus.signed_div && bus.opdata1[WIDTH-1] ? -bus.opdata1 : bus.opdata1;
        abs2 = bus.signed_div && bus.opdata2[WIDTH-1] ? -bus.opdata2 : bus.opdata2;
        shr = {rem, dvd[WIDTH-1]};
        diff = shr - {1'b0, dsr};
        // rem < dsr keeps diff below 2^WIDTH when non-negative, so the MSB is a pure borrow
        nrem = diff[WIDTH] ? shr[WIDTH-1:0] : diff[WIDTH-1:0];
        ndvd = {dvd[WIDTH-2:0], !diff[WIDTH]};
        q = qsign ? -ndvd : ndvd;
        r = rsign ? -nrem : nrem;
    end
    assign bus.stall = accept || state == CALC;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            rem <= '0;
            dvd <= '0;
            dsr <= '0;
            raw1 <= '0;
            cnt <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            zero <= 1'b0;
            bus.result <= '0;
            bus.ready <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    rem <= '0;
                    dvd <= abs1;
                    dsr <= abs2;
                    raw1 <= bus.opdata1;
                    cnt <= '0;
                    zero <= bus.opdata2 == '0;
                    qsign <= bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                    rsign <= bus.signed_div && bus.opdata1[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
                    if (bus.opdata2 == '0) begin
                        bus.result <= {bus.opdata1, {WIDTH{1'b1}}};
                        bus.ready <= 1'b1;
                        state <= DONE;
                    end else
                        state <= CALC;
`else
                    state <= CALC;
`endif
                end
                CALC: if (bus.annul) begin
                    state <= IDLE;
                    cnt <= '0;
                end else begin
                    rem <= nrem;
                    dvd <= ndvd;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.result <= zero ? {raw1, {WIDTH{1'b1}}} : {r, q};
                        bus.ready <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq covering DIV/DIVU, overflow, zero divisor, annul and reset
module tb_div_seq;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;
    div_seq_if #(.WIDTH(32)) bus();
    div_seq #(.WIDTH(32)) dut(.clk(clk), .resetn(resetn), .bus(bus));
    int tests = 0, fails = 0;
    logic [63:0] sb[$];
    logic [63:0] last = '0;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, qq, rr;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!sd) return {a % b, a / b};
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        qq = sa / sbv;
        rr = sa % sbv;
        return {rr[31:0], qq[31:0]};
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run(input logic sd, input logic [31:0] a, input logic [31:0] b, input int lat);
        int st;
        logic seen;
        sb.push_back(model(sd, a, b));
        bus.start = 1'b1;
        bus.signed_div = sd;
        bus.opdata1 = a;
        bus.opdata2 = b;
        seen = 1'b0;
        st = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                seen = 1'b1;
                check("latency", c, lat);
                check("stall_in_done", bus.stall, 0);
                last = sb.pop_front();
                check("result", bus.result, last);
            end else
                st += int'(bus.stall);
            tick();
        end
        check("ready_seen", seen, 1);
        if (!seen) void'(sb.pop_front());
        check("stall_cycles", st, lat);
        bus.start = 1'b0;
    endtask
    initial begin
        int rdy;
        logic [31:0] a, b;
        logic sd;
        resetn = 1'b0;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.annul = 1'b0;
        bus.opdata1 = '0;
        bus.opdata2 = '0;
        repeat (2) tick();
        check("reset_ready", bus.ready, 0);
        check("reset_stall", bus.stall, 0);
        check("reset_result", bus.result, 0);
        resetn = 1'b1;
        tick();
        run(1'b0, 32'd100, 32'd7, 33);
        run(1'b1, 32'hFFFF_FFF9, 32'h2, 33);
        run(1'b0, 32'hFFFF_FFF9, 32'h2, 33);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        run(1'b0, 32'h1234, 32'h0, ZLAT);
        run(1'b1, 32'hFFFF_FF00, 32'h0, ZLAT);
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1 = 32'd100;
        bus.opdata2 = 32'd7;
        rdy = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 10) begin
                bus.annul = 1'b1;
                bus.start = 1'b0;
            end
            @(negedge clk);
            rdy += int'(bus.ready);
            tick();
        end
        bus.annul = 1'b0;
        @(negedge clk);
        check("annul_stall", bus.stall, 0);
        check("annul_ready", bus.ready, 0);
        check("annul_result_kept", bus.result, last);
        check("annul_no_ready_before", rdy, 0);
        tick();
        run(1'b0, 32'd100, 32'd7, 33);
        for (int i = 0; i < 6; i++) begin
            sd = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run(sd, a, b, b == 0 ? ZLAT : 33);
        end
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1 = 32'd100;
        bus.opdata2 = 32'd7;
        repeat (5) tick();
        resetn = 1'b0;
        bus.start = 1'b0;
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_result", bus.result, 0);
        tick();
        resetn = 1'b1;
        rdy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rdy += int'(bus.ready);
        end
        check("rst_no_ready", rdy, 0);
        tick();
        run(1'b1, 32'hFFFF_FF9C, 32'd7, 33);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
